// File: rtl/rtc_pkg.sv
// Shared definitions for the DS1302 command path: one-hot command codes,
// DS1302 register addresses, write-protect values and the executor FSM states.
package rtc_pkg;

    // One-hot command codes as presented on cmd_sig
    localparam logic [7:0] CMD_WRITE_UNPROTECT = 8'h80;
    localparam logic [7:0] CMD_WRITE_HOUR      = 8'h40;
    localparam logic [7:0] CMD_WRITE_MINUTE    = 8'h20;
    localparam logic [7:0] CMD_WRITE_SECOND    = 8'h10;
    localparam logic [7:0] CMD_WRITE_PROTECT   = 8'h08;
    localparam logic [7:0] CMD_READ_HOUR       = 8'h04;
    localparam logic [7:0] CMD_READ_MINUTE     = 8'h02;
    localparam logic [7:0] CMD_READ_SECOND     = 8'h01;

    // DS1302 register addresses (write form; read form sets bit 0)
    localparam logic [7:0] ADDR_SEC_W = 8'h80;
    localparam logic [7:0] ADDR_MIN_W = 8'h82;
    localparam logic [7:0] ADDR_HR_W  = 8'h84;
    localparam logic [7:0] ADDR_WP    = 8'h8E;

    // Write-protect register contents
    localparam logic [7:0] WP_ON  = 8'h80;
    localparam logic [7:0] WP_OFF = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_RECOV,
        ST_DONE
    } exec_state_t;

    // Read access uses the write address with the RD/W bit set
    function automatic logic [7:0] rd_addr(input logic [7:0] addr);
        return addr | 8'h01;
    endfunction

endpackage

// File: rtl/rtc_cmd_decode.sv
// Combinational priority decoder: one-hot command -> DS1302 address/data.
// When more than one bit is set the highest-numbered bit wins.
module rtc_cmd_decode
    import rtc_pkg::*;
(
    input  logic [7:0] cmd_sig,
    output logic [7:0] addr,
    output logic [7:0] fixed_data,
    output logic       use_wdata,
    output logic       is_read
);

    // Priority chain from bit 7 down to bit 0
    always_comb begin
        addr       = 8'h00;
        fixed_data = 8'h00;
        use_wdata  = 1'b0;
        is_read    = 1'b0;
        if ((cmd_sig & CMD_WRITE_UNPROTECT) != 8'h00) begin
            addr       = ADDR_WP;
            fixed_data = WP_OFF;
        end else if ((cmd_sig & CMD_WRITE_HOUR) != 8'h00) begin
            addr      = ADDR_HR_W;
            use_wdata = 1'b1;
        end else if ((cmd_sig & CMD_WRITE_MINUTE) != 8'h00) begin
            addr      = ADDR_MIN_W;
            use_wdata = 1'b1;
        end else if ((cmd_sig & CMD_WRITE_SECOND) != 8'h00) begin
            addr      = ADDR_SEC_W;
            use_wdata = 1'b1;
        end else if ((cmd_sig & CMD_WRITE_PROTECT) != 8'h00) begin
            addr       = ADDR_WP;
            fixed_data = WP_ON;
        end else if ((cmd_sig & CMD_READ_HOUR) != 8'h00) begin
            addr    = rd_addr(ADDR_HR_W);
            is_read = 1'b1;
        end else if ((cmd_sig & CMD_READ_MINUTE) != 8'h00) begin
            addr    = rd_addr(ADDR_MIN_W);
            is_read = 1'b1;
        end else if ((cmd_sig & CMD_READ_SECOND) != 8'h00) begin
            addr    = rd_addr(ADDR_SEC_W);
            is_read = 1'b1;
        end
    end

endmodule

// File: rtl/ds1302_cmd_exec.sv
// DS1302 single-byte transaction executor. Accepts one command at a time,
// drives CE/SCLK/IO through setup, 16 SCLK pulses, hold and recovery, then
// pulses cmd_done for one cycle. All pin outputs come straight from flops.
module ds1302_cmd_exec
    import rtc_pkg::*;
#(
    parameter int unsigned SCLK_HALF = 50,
    parameter int unsigned CE_SETUP  = 200,
    parameter int unsigned CE_HOLD   = 200,
    parameter int unsigned CE_IDLE   = 200
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cmd_sig,
    input  logic [7:0] time_write_data,
    output logic       cmd_done,
    output logic [7:0] time_read_data,
    output logic       rtc_ce,
    output logic       rtc_sclk,
    inout  wire        rtc_io
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CE_SETUP - 1);
    localparam logic [CNT_W-1:0] LOW_LAST   = CNT_W'(SCLK_HALF - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(2 * SCLK_HALF - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CE_HOLD - 1);
    localparam logic [CNT_W-1:0] RECOV_LAST = CNT_W'(CE_IDLE - 1);

    exec_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [15:0]      tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic             is_read_q, is_read_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             ce_q, ce_d;
    logic             sclk_q, sclk_d;
    logic             io_oe_q, io_oe_d;
    logic             io_out_q, io_out_d;
    logic [3:0]       bit_nx;

    logic [7:0] dec_addr;
    logic [7:0] dec_fixed_data;
    logic       dec_use_wdata;
    logic       dec_is_read;

    rtc_cmd_decode u_decode (
        .cmd_sig    (cmd_sig),
        .addr       (dec_addr),
        .fixed_data (dec_fixed_data),
        .use_wdata  (dec_use_wdata),
        .is_read    (dec_is_read)
    );

    assign rtc_io         = io_oe_q ? io_out_q : 1'bz;
    assign rtc_ce         = ce_q;
    assign rtc_sclk       = sclk_q;
    assign time_read_data = rdata_q;
    assign cmd_done       = (state_q == ST_DONE);

    // Next-state, counter, shift-register and pin-level computation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        is_read_d = is_read_q;
        rdata_d   = rdata_q;
        ce_d      = ce_q;
        sclk_d    = sclk_q;
        io_oe_d   = io_oe_q;
        io_out_d  = io_out_q;
        bit_nx    = bit_q + 4'd1;

        case (state_q)
            ST_IDLE: begin
                if (cmd_sig != 8'h00) begin
                    tx_d      = {(dec_use_wdata ? time_write_data : dec_fixed_data), dec_addr};
                    is_read_d = dec_is_read;
                    ce_d      = 1'b1;
                    cnt_d     = '0;
                    bit_d     = 4'd0;
                    io_oe_d   = 1'b1;
                    io_out_d  = dec_addr[0];
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    // Pulse 1 low phase: bit 0 stays on IO
                    cnt_d    = '0;
                    bit_d    = 4'd0;
                    io_out_d = tx_q[0];
                    state_d  = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == LOW_LAST) begin
                    // Rising edge: the DS1302 samples our bit, or we sample its bit
                    sclk_d = 1'b1;
                    if (is_read_q && bit_q[3]) begin
                        rx_d = {rtc_io, rx_q[7:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                end else if (cnt_q == PULSE_LAST) begin
                    sclk_d = 1'b0;
                    cnt_d  = '0;
                    if (bit_q == 4'd15) begin
                        io_oe_d = 1'b0;
                        state_d = ST_HOLD;
                    end else begin
                        // Next pulse's low phase starts: present its bit, or
                        // release IO for the data byte of a read
                        bit_d    = bit_nx;
                        io_out_d = tx_q[bit_nx];
                        io_oe_d  = !(is_read_q && bit_nx[3]);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    ce_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RECOV;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RECOV: begin
                if (cnt_q == RECOV_LAST) begin
                    if (is_read_q) begin
                        rdata_d = rx_q;
                    end
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and pin registers; reset aborts any transfer immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= 4'd0;
            tx_q      <= 16'h0000;
            rx_q      <= 8'h00;
            is_read_q <= 1'b0;
            rdata_q   <= 8'h00;
            ce_q      <= 1'b0;
            sclk_q    <= 1'b0;
            io_oe_q   <= 1'b0;
            io_out_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            is_read_q <= is_read_d;
            rdata_q   <= rdata_d;
            ce_q      <= ce_d;
            sclk_q    <= sclk_d;
            io_oe_q   <= io_oe_d;
            io_out_q  <= io_out_d;
        end
    end

endmodule
